// File: rtl/combo_entry_pkg.sv
// Shared types, key codes and BCD/one-hot helpers for the combination-lock keypad front end.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package combo_entry_pkg;

    localparam int KEY_CLEAR        = 10;
    localparam int KEY_ENTER        = 11;
    localparam int GROUPS           = 3;
    localparam int DIGITS_PER_GROUP = 4;
    localparam int NUM_SLOTS        = GROUPS * DIGITS_PER_GROUP;

    typedef enum logic [2:0] {
        ENTRY,
        BURST0,
        BURST1,
        BURST2,
        CHECK,
        LOCKOUT
    } entry_state_t;

    typedef logic [9:0]                        onehot_t;
    typedef logic [DIGITS_PER_GROUP-1:0][9:0]  digits_t;
    typedef logic [DIGITS_PER_GROUP-1:0][3:0]  bcd_group_t;

    // Every position showing digit 0: the pattern the lock sees between attempts.
    localparam digits_t DIGITS_IDLE = {DIGITS_PER_GROUP{10'b00_0000_0001}};

    // Out-of-range codes map to digit 0 so the lock input never loses its one-hot shape.
    function automatic onehot_t bcd_to_onehot(input logic [3:0] bcd);
        onehot_t oh;
        oh = 10'b00_0000_0001;
        if (bcd <= 4'd9) begin
            oh = onehot_t'(1) << bcd;
        end
        return oh;
    endfunction

    function automatic digits_t group_to_digits(input bcd_group_t grp);
        digits_t d;
        for (int k = 0; k < DIGITS_PER_GROUP; k++) begin
            d[k] = bcd_to_onehot(grp[k]);
        end
        return d;
    endfunction

endpackage

// File: rtl/combo_entry_sequencer_if.sv
// Keypad/lock-side bundle of the entry sequencer: key strobe, lock feedback and status outputs.
// Latency: none (wiring only).
// Backpressure: key_ready low means the keypad strobe is dropped, never queued.
interface combo_entry_sequencer_if;
    import combo_entry_pkg::*;

    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready;
    logic       open;
    digits_t    digits;
    logic [3:0] entry_count;
    logic       err;
    logic       fail_pulse;
    logic       locked_out;

    // Keypad plus lock side: drives keys and the lock result, observes status.
    modport master (
        output key_valid, key_code, open,
        input  key_ready, digits, entry_count, err, fail_pulse, locked_out
    );

    // Sequencer side.
    modport slave (
        input  key_valid, key_code, open,
        output key_ready, digits, entry_count, err, fail_pulse, locked_out
    );

endinterface

// File: rtl/entry_buffer.sv
// Twelve-slot BCD key store with fill count, overflow flag and 4-digit group read-out.
// Latency: writes/clears visible one cycle later; group read-out is combinational.
// Backpressure: none; a write with the buffer full is dropped and sets the overflow flag.
module entry_buffer
    import combo_entry_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [3:0] wr_dat,
    input  logic       clr,
    input  logic [1:0] rd_grp,
    output logic [3:0] count,
    output logic       ovf,
    output bcd_group_t rd_dat
);

    logic [NUM_SLOTS-1:0][3:0] mem_q, mem_d;
    logic [3:0]                count_q, count_d;
    logic                      ovf_q, ovf_d;
    logic [3:0]                base;

    // Next-state of the store: clear wins over a write in the same cycle.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (wr_en) begin
            if (count_q < 4'(NUM_SLOTS)) begin
                mem_d[count_q] = wr_dat;
                count_d        = count_q + 4'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    // Store registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Group read-out: the first key of a group lands in the thousands position.
    always_comb begin
        base = (rd_grp < 2'(GROUPS)) ? {rd_grp, 2'b00} : 4'd0;
        rd_dat    = '0;
        rd_dat[3] = mem_q[base];
        rd_dat[2] = mem_q[base + 4'd1];
        rd_dat[1] = mem_q[base + 4'd2];
        rd_dat[0] = mem_q[base + 4'd3];
    end

    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/combo_entry_sequencer.sv
// Keypad front end: buffers 12 digits, bursts them as three one-hot groups into the lock, tracks failures.
// Latency: groups on digits 1..3 cycles after Enter; lock result sampled at +4, fail/lockout visible at +5.
// Backpressure: key_ready only in ENTRY; keys offered elsewhere are silently dropped.
module combo_entry_sequencer
    import combo_entry_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    rst,
    combo_entry_sequencer_if.slave  bus
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int FAIL_W  = $clog2(MAX_FAILS + 1);
    localparam int LOCK_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(MAX_FAILS);
    localparam logic [LOCK_W-1:0]  LOCK_LAST  = LOCK_W'(LOCKOUT_CYCLES - 1);

    entry_state_t       state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [FAIL_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic [FAIL_W-1:0]  fail_next;
    logic [LOCK_W-1:0]  lock_cnt_q, lock_cnt_d;
    digits_t            digits_q, digits_d;
    logic               err_q, err_d;
    logic               fail_pulse_q, fail_pulse_d;

    logic               key_acc;
    logic               is_digit;
    logic               is_clear;
    logic               is_enter;

    logic               buf_wr;
    logic               buf_clr;
    logic [1:0]         buf_grp;
    logic [3:0]         buf_count;
    logic               buf_ovf;
    bcd_group_t         buf_rd;

    assign key_acc  = bus.key_valid && (state_q == ENTRY);
    assign is_digit = (bus.key_code <= 4'd9);
    assign is_clear = (bus.key_code == 4'(KEY_CLEAR));
    assign is_enter = (bus.key_code == 4'(KEY_ENTER));

    // During BURSTn the next group is prepared so it is registered onto digits one cycle later.
    assign buf_grp = (state_q == BURST0) ? 2'd1 :
                     (state_q == BURST1) ? 2'd2 : 2'd0;

    assign fail_next = (fail_cnt_q == FAIL_MAX) ? FAIL_MAX : fail_cnt_q + 1'b1;

    entry_buffer u_buf (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (buf_wr),
        .wr_dat (bus.key_code),
        .clr    (buf_clr),
        .rd_grp (buf_grp),
        .count  (buf_count),
        .ovf    (buf_ovf),
        .rd_dat (buf_rd)
    );

    // Next-state, timers, failure bookkeeping and the registered lock input.
    always_comb begin
        state_d      = state_q;
        timer_d      = '0;
        fail_cnt_d   = fail_cnt_q;
        lock_cnt_d   = '0;
        digits_d     = DIGITS_IDLE;
        err_d        = 1'b0;
        fail_pulse_d = 1'b0;
        buf_wr       = 1'b0;
        buf_clr      = 1'b0;

        case (state_q)
            ENTRY: begin
                if (key_acc && is_digit) begin
                    buf_wr = 1'b1;
                end else if (key_acc && is_clear) begin
                    buf_clr = 1'b1;
                end else if (key_acc && is_enter) begin
                    if ((buf_count == 4'(NUM_SLOTS)) && !buf_ovf) begin
                        state_d  = BURST0;
                        digits_d = group_to_digits(buf_rd);
                    end else begin
                        err_d   = 1'b1;
                        buf_clr = 1'b1;
                    end
                end else if (buf_count != 4'd0) begin
                    // Idle cycle (or an ignored code) with a partial entry pending.
                    if (timer_q >= TIMER_LAST) begin
                        err_d   = 1'b1;
                        buf_clr = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            BURST0: begin
                digits_d = group_to_digits(buf_rd);
                state_d  = BURST1;
            end
            BURST1: begin
                digits_d = group_to_digits(buf_rd);
                state_d  = BURST2;
            end
            BURST2: begin
                state_d = CHECK;
            end
            CHECK: begin
                buf_clr = 1'b1;
                if (bus.open) begin
                    fail_cnt_d = '0;
                    state_d    = ENTRY;
                end else begin
                    fail_pulse_d = 1'b1;
                    if (fail_next >= FAIL_MAX) begin
                        fail_cnt_d = '0;
                        state_d    = LOCKOUT;
                    end else begin
                        fail_cnt_d = fail_next;
                        state_d    = ENTRY;
                    end
                end
            end
            LOCKOUT: begin
                if (lock_cnt_q >= LOCK_LAST) begin
                    state_d = ENTRY;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ENTRY;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ENTRY;
            timer_q      <= '0;
            fail_cnt_q   <= '0;
            lock_cnt_q   <= '0;
            digits_q     <= DIGITS_IDLE;
            err_q        <= 1'b0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            fail_cnt_q   <= fail_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            digits_q     <= digits_d;
            err_q        <= err_d;
            fail_pulse_q <= fail_pulse_d;
        end
    end

    assign bus.digits      = digits_q;
    assign bus.key_ready   = (state_q == ENTRY);
    assign bus.entry_count = buf_count;
    assign bus.err         = err_q;
    assign bus.fail_pulse  = fail_pulse_q;
    assign bus.locked_out  = (state_q == LOCKOUT);

endmodule

// File: tb/tb_combo_entry_sequencer.sv
// Directed bench for combo_entry_sequencer: vector table for single-key behaviour plus multi-cycle sequences.
// Latency: inputs driven 1 time unit after posedge, outputs compared 1 time unit after the next posedge.
// Backpressure: keys deliberately offered while key_ready is low to confirm they are dropped.
module tb_combo_entry_sequencer;

    localparam int T_TO = 20;
    localparam int T_MF = 3;
    localparam int T_LO = 30;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    combo_entry_sequencer_if bus ();

    combo_entry_sequencer #(
        .TIMEOUT_CYCLES (T_TO),
        .MAX_FAILS      (T_MF),
        .LOCKOUT_CYCLES (T_LO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic       kv;
        logic [3:0] code;
        logic [3:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [9:0] oh(input int d);
        logic [9:0] v;
        v    = '0;
        v[d] = 1'b1;
        return v;
    endfunction

    // Thousands digit first, units digit last.
    function automatic logic [39:0] grp(input int a, input int b, input int c, input int d);
        return {oh(a), oh(b), oh(c), oh(d)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] code);
        bus.key_valid = 1'b1;
        bus.key_code  = code;
        step();
        bus.key_valid = 1'b0;
    endtask

    // Twelve digits, slot 0 in the top nibble.
    task automatic press12(input logic [47:0] d);
        for (int i = 0; i < 12; i++) begin
            press(d[47-4*i -: 4]);
        end
    endtask

    task automatic wrong_attempt(input string tag, input logic exp_lock);
        press12(48'h1111_1111_1111);
        press(4'd11);
        repeat (3) step();
        chk({tag, "_fail_nopulse_T4"}, 64'(bus.fail_pulse), 64'(0));
        step();
        chk({tag, "_fail_pulse"}, 64'(bus.fail_pulse), 64'(1));
        chk({tag, "_locked_out"}, 64'(bus.locked_out), 64'(exp_lock));
        chk({tag, "_key_ready"}, 64'(bus.key_ready), 64'(!exp_lock));
        chk({tag, "_count_clr"}, 64'(bus.entry_count), 64'(0));
    endtask

    initial begin
        int lo_cycles;
        logic [39:0] idle;
        idle = grp(0, 0, 0, 0);

        vecs[0] = '{1'b0, 4'd0,  4'd0, 1'b0};
        vecs[1] = '{1'b1, 4'd5,  4'd1, 1'b0};
        vecs[2] = '{1'b1, 4'd12, 4'd1, 1'b0};
        vecs[3] = '{1'b1, 4'd7,  4'd2, 1'b0};
        vecs[4] = '{1'b1, 4'd10, 4'd0, 1'b0};
        vecs[5] = '{1'b1, 4'd11, 4'd0, 1'b1};
        vecs[6] = '{1'b0, 4'd0,  4'd0, 1'b0};
        vecs[7] = '{1'b1, 4'd1,  4'd1, 1'b0};
        vecs[8] = '{1'b1, 4'd11, 4'd0, 1'b1};
        vecs[9] = '{1'b1, 4'd15, 4'd0, 1'b0};

        // Reset values.
        rst           = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        bus.open      = 1'b0;
        step();
        step();
        chk("rst_digits", 64'(bus.digits), 64'(idle));
        chk("rst_count", 64'(bus.entry_count), 64'(0));
        chk("rst_err", 64'(bus.err), 64'(0));
        chk("rst_fail", 64'(bus.fail_pulse), 64'(0));
        chk("rst_locked", 64'(bus.locked_out), 64'(0));
        chk("rst_ready", 64'(bus.key_ready), 64'(1));
        rst = 1'b1;
        step();

        // Single-key behaviour table.
        for (int i = 0; i < 10; i++) begin
            bus.key_valid = vecs[i].kv;
            bus.key_code  = vecs[i].code;
            step();
            chk($sformatf("vec%0d_count", i), 64'(bus.entry_count), 64'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_err", i), 64'(bus.err), 64'(vecs[i].exp_err));
            chk($sformatf("vec%0d_ready", i), 64'(bus.key_ready), 64'(1));
            chk($sformatf("vec%0d_digits", i), 64'(bus.digits), 64'(idle));
        end
        bus.key_valid = 1'b0;
        step();

        // Correct entry: burst timing, keys dropped during BURST/CHECK, open=1 gives no fail.
        bus.open = 1'b1;
        press12(48'h3372_0000_3372);
        chk("ok_count12", 64'(bus.entry_count), 64'(12));
        press(4'd11);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd9;
        chk("ok_grp0", 64'(bus.digits), 64'(grp(3, 3, 7, 2)));
        chk("ok_ready_burst", 64'(bus.key_ready), 64'(0));
        step();
        chk("ok_grp1", 64'(bus.digits), 64'(grp(0, 0, 0, 0)));
        chk("ok_burst1_ready", 64'(bus.key_ready), 64'(0));
        step();
        chk("ok_grp2", 64'(bus.digits), 64'(grp(3, 3, 7, 2)));
        step();
        chk("ok_idle_T4", 64'(bus.digits), 64'(idle));
        chk("ok_ready_T4", 64'(bus.key_ready), 64'(0));
        step();
        bus.key_valid = 1'b0;
        chk("ok_no_fail", 64'(bus.fail_pulse), 64'(0));
        chk("ok_ready_T5", 64'(bus.key_ready), 64'(1));
        chk("ok_locked_T5", 64'(bus.locked_out), 64'(0));
        chk("ok_count_T5", 64'(bus.entry_count), 64'(0));
        step();
        chk("ok_count_after", 64'(bus.entry_count), 64'(0));
        bus.open = 1'b0;

        // Eleven digits then Enter.
        repeat (11) press(4'd4);
        chk("short_count11", 64'(bus.entry_count), 64'(11));
        press(4'd11);
        chk("short_err", 64'(bus.err), 64'(1));
        chk("short_count", 64'(bus.entry_count), 64'(0));
        chk("short_ready", 64'(bus.key_ready), 64'(1));
        chk("short_digits", 64'(bus.digits), 64'(idle));
        step();
        chk("short_err_pulse", 64'(bus.err), 64'(0));

        // Thirteen digits then Enter.
        press12(48'h1234_5678_9012);
        press(4'd5);
        chk("ovf_count12", 64'(bus.entry_count), 64'(12));
        chk("ovf_no_err", 64'(bus.err), 64'(0));
        press(4'd11);
        chk("ovf_err", 64'(bus.err), 64'(1));
        chk("ovf_count", 64'(bus.entry_count), 64'(0));
        chk("ovf_no_burst", 64'(bus.digits), 64'(idle));

        // Three failures lead to lockout; keys offered every lockout cycle.
        wrong_attempt("f1", 1'b0);
        step();
        chk("f1_pulse_once", 64'(bus.fail_pulse), 64'(0));
        wrong_attempt("f2", 1'b0);
        wrong_attempt("f3", 1'b1);
        lo_cycles = 0;
        while (bus.locked_out && lo_cycles < T_LO + 20) begin
            lo_cycles++;
            bus.key_valid = 1'b1;
            bus.key_code  = 4'd4;
            step();
        end
        bus.key_valid = 1'b0;
        chk("lockout_len", 64'(lo_cycles), 64'(T_LO));
        chk("lockout_dropped", 64'(bus.entry_count), 64'(0));
        chk("lockout_ready", 64'(bus.key_ready), 64'(1));
        step();

        // Timeout after five digits.
        repeat (5) press(4'd8);
        repeat (T_TO - 1) step();
        chk("to_pre_err", 64'(bus.err), 64'(0));
        chk("to_pre_count", 64'(bus.entry_count), 64'(5));
        step();
        chk("to_err", 64'(bus.err), 64'(1));
        chk("to_count", 64'(bus.entry_count), 64'(0));
        step();
        chk("to_err_pulse", 64'(bus.err), 64'(0));

        // Key on the expiry cycle wins over the timeout.
        repeat (5) press(4'd8);
        repeat (T_TO - 1) step();
        press(4'd6);
        chk("tokey_count", 64'(bus.entry_count), 64'(6));
        chk("tokey_err", 64'(bus.err), 64'(0));
        step();
        chk("tokey_err_next", 64'(bus.err), 64'(0));
        press(4'd10);
        chk("clear_count", 64'(bus.entry_count), 64'(0));
        chk("clear_err", 64'(bus.err), 64'(0));

        // Reset during BURST1 with two failures banked: counter must be cleared.
        wrong_attempt("r1", 1'b0);
        wrong_attempt("r2", 1'b0);
        press12(48'h1111_1111_1111);
        press(4'd11);
        step();
        rst = 1'b0;
        step();
        chk("rb_digits", 64'(bus.digits), 64'(idle));
        chk("rb_ready", 64'(bus.key_ready), 64'(1));
        chk("rb_count", 64'(bus.entry_count), 64'(0));
        chk("rb_err", 64'(bus.err), 64'(0));
        chk("rb_fail", 64'(bus.fail_pulse), 64'(0));
        chk("rb_locked", 64'(bus.locked_out), 64'(0));
        rst = 1'b1;
        step();
        wrong_attempt("r3", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/combo_entry_sequencer.md
# combo_entry_sequencer

Keypad front end for `combination_lock`. It collects twelve single-digit keypresses, and on Enter replays them as three 4-digit one-hot groups on three consecutive cycles into the lock's `digits` input. It then samples the lock's `open` output to count failed attempts, and enforces a timed lockout after repeated failures.

## Interface
- `TIMEOUT_CYCLES`, default 1000: idle cycles after the last accepted key before a partial entry is discarded.
- `MAX_FAILS`, default 3: consecutive failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, default 5000: lockout duration in cycles.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-low.
- `key_valid`  in  1  one-cycle keypress strobe.
- `key_code`  in  4  0–9 digit, 10 Clear, 11 Enter, 12–15 ignored.
- `open`  in  1  from `combination_lock`.
- `digits`  out  10×[3:0]  one-hot per position; `digits[0]` is the units digit. Registered.
- `key_ready`  out  1  high only in ENTRY.
- `entry_count`  out  4  digits buffered, 0..12.
- `err`  out  1  one-cycle pulse: bad Enter or timeout.
- `fail_pulse`  out  1  one-cycle pulse: attempt rejected.
- `locked_out`  out  1  high during LOCKOUT.

## Operation
- Reset values:
  - `digits` = idle pattern, every position one-hot digit 0 (10'b1).
  - `entry_count`, `err`, `fail_pulse`, `locked_out` = 0.
  - `key_ready` = 1.
  - Fail counter = 0; state = ENTRY.
- `digits` is always one-hot in every position, including during reset.
- States: ENTRY, BURST0, BURST1, BURST2, CHECK, LOCKOUT.
- ENTRY, action per accepted key (`key_valid && key_ready`):
  - Digit with count < 12: stored at slot `count`; count increments.
  - Digit with count = 12: dropped; overflow flag set.
  - Clear: count and overflow flag go to 0; no `err`.
  - Enter with count = 12 and no overflow: go to BURST0.
  - Any other Enter: `err` pulse, buffer cleared, stay in ENTRY.
  - Codes 12–15: ignored; timer not reset.
- Slot mapping: slot `4g+k` goes to group g, position `3-k`. The first key of each group is the thousands digit.
- BURST0, BURST1, BURST2: `digits` shows group 0, 1, 2 respectively. After BURST2, `digits` returns to idle and the state goes to CHECK.
- CHECK samples `open`:
  - `open` = 1: fail counter cleared; go to ENTRY.
  - `open` = 0: `fail_pulse`, fail counter +1. If the counter reaches `MAX_FAILS`, go to LOCKOUT and clear the counter; otherwise go to ENTRY.
  - Either way, the buffer and count are cleared.
- LOCKOUT: all keys dropped. After `LOCKOUT_CYCLES` cycles, go to ENTRY.
- Timeout (ENTRY, count > 0): the timer resets on each accepted key. When it reaches `TIMEOUT_CYCLES`: `err` pulse, buffer cleared.
- Keys arriving outside ENTRY are dropped silently and are not queued.

## Timing
- Enter accepted at cycle T:
  - Group 0 on `digits` at T+1, group 1 at T+2, group 2 at T+3.
  - Idle at T+4; CHECK samples `open` at T+4.
  - `fail_pulse` and `locked_out` visible at T+5.
  - `key_ready` high again at T+5 when not locked out.
- `err` asserts the cycle after the offending Enter, or the cycle after the timer expires.
- `entry_count` updates the cycle after the accepted key.
- Timer expiry and an accepted key in the same cycle: the key wins. It is stored and the timer is reset.
- The `LOCKOUT_CYCLES`-th lockout cycle is the last with `locked_out` = 1.
- Reset asserted mid-burst: `digits` is idle the next cycle; fail counter and lockout are cleared.
- Counter widths are `$clog2(param+1)`. Counters saturate and never wrap.

## Structure
- Package `combo_entry_pkg` holds:
  - `KEY_CLEAR` = 10, `KEY_ENTER` = 11.
  - `GROUPS` = 3, `DIGITS_PER_GROUP` = 4.
  - State enum `entry_state_t`.
  - Function `bcd_to_onehot` (4-bit to 10-bit).
- Sub-module `entry_buffer`: 12×4-bit BCD store with write port, count, clear, overflow flag, and group read-out. The top level holds the FSM, timers and fail counter.

## Test plan
- Keys 3,3,7,2 / 0,0,0,0 / 3,3,7,2, then Enter at T:
  - `digits` = `'{C2,C7,C3,C3}`, `'{C0,C0,C0,C0}`, `'{C2,C7,C3,C3}` at T+1..T+3.
  - `open` = 1 at T+4 gives no `fail_pulse`.
- Eleven digits, then Enter: `err` at the next cycle, `entry_count` = 0, no burst. A 13th digit followed by Enter also gives `err`.
- Three wrong 12-digit entries with `open` held 0:
  - `fail_pulse` ×3.
  - `locked_out` high for exactly `LOCKOUT_CYCLES`; keys dropped throughout.
- Five digits, then an idle gap of `TIMEOUT_CYCLES`: `err` pulse, count = 0. A key on the expiry cycle instead gives count = 6 and no `err`.
- `rst` low during BURST1: `digits` idle next cycle, state ENTRY, all outputs at reset values.
- Digits during BURST and CHECK: dropped, `entry_count` stays 0 afterwards. Clear mid-entry: count = 0, no `err`.
